// File: rtl/uart_cmd_if.sv
// Bundle of the UART byte stream, single-beat bus and response signals around uart_cmd_ctrl.
// The controller uses the master view; the surrounding system uses the slave view.
interface uart_cmd_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic        frame_err;
  logic        cmd_err;

  modport master (
    input  rx_valid, rx_data, bus_ack, bus_rdata, tx_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, tx_valid, tx_data,
           busy, overrun, frame_err, cmd_err
  );

  modport slave (
    output rx_valid, rx_data, bus_ack, bus_rdata, tx_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, tx_valid, tx_data,
           busy, overrun, frame_err, cmd_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses write/read frames into single-beat bus transactions.
// Optional macro UART_CMD_WR_ACK_EN: completed writes return ACK_BYTE on the transmitter.
//
// state   | meaning
// IDLE    | waiting for a command byte
// ADDR_HI | waiting for address high byte
// ADDR_LO | waiting for address low byte
// DATA    | waiting for write data byte
// BUS     | bus_req held until bus_ack
// RESP    | tx_valid held until tx_ready
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic       clk,
  input  logic       rst,
  uart_cmd_if.master io
);

  localparam int unsigned    TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TLOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          bus_we_q, bus_we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          cmd_err_q, cmd_err_d;
  logic          bus_req_q, tx_valid_q, busy_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          in_frame;

  assign in_frame = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      tmr_q       <= TLOAD;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
      bus_req_q   <= (state_d == S_BUS);
      tx_valid_q  <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      tmr_q       <= tmr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    cmd_err_d   = 1'b0;
    tmr_d       = tmr_q;

    case (state_q)
      S_IDLE: begin
        if (io.rx_valid) begin
          if (io.rx_data == CMD_WR) begin
            bus_we_d = 1'b1;
            state_d  = S_ADDR_HI;
          end else if (io.rx_data == CMD_RD) begin
            bus_we_d = 1'b0;
            state_d  = S_ADDR_HI;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_ADDR_HI: begin
        if (io.rx_valid) begin
          addr_d[15:8] = io.rx_data;
          state_d      = S_ADDR_LO;
        end else if (tmr_q == '0) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_ADDR_LO: begin
        if (io.rx_valid) begin
          addr_d[7:0] = io.rx_data;
          state_d     = bus_we_q ? S_DATA : S_BUS;
        end else if (tmr_q == '0) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_DATA: begin
        if (io.rx_valid) begin
          wdata_d = io.rx_data;
          state_d = S_BUS;
        end else if (tmr_q == '0) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_BUS: begin
        if (io.rx_valid) overrun_d = 1'b1;
        if (io.bus_ack) begin
          // tx_data only means something while tx_valid is high
          tx_data_d = bus_we_q ? ACK_BYTE : io.bus_rdata;
`ifdef UART_CMD_WR_ACK_EN
          state_d = S_RESP;
`else
          state_d = bus_we_q ? S_IDLE : S_RESP;
`endif
        end
      end
      S_RESP: begin
        if (io.rx_valid) overrun_d = 1'b1;
        if (io.tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // byte arrival or any state change restarts the inter-byte window
    if (io.rx_valid || (state_d != state_q)) begin
      tmr_d = TLOAD;
    end else if (in_frame && (tmr_q != '0)) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  assign io.bus_req   = bus_req_q;
  assign io.bus_we    = bus_we_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_wdata = wdata_q;
  assign io.tx_valid  = tx_valid_q;
  assign io.tx_data   = tx_data_q;
  assign io.busy      = busy_q;
  assign io.overrun   = overrun_q;
  assign io.frame_err = frame_err_q;
  assign io.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl: frame-level memory scoreboard plus directed timing cases.
module tb_uart_cmd_ctrl;
  localparam int unsigned TO     = 20;
  localparam logic [7:0]  CMD_WR = 8'h57;
  localparam logic [7:0]  CMD_RD = 8'h52;
  localparam logic [7:0]  ACK_B  = 8'h06;
`ifdef UART_CMD_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  uart_cmd_if u_if ();

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .io(u_if));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  slave_mem [65536];
  logic [7:0]  ref_mem   [65536];
  logic        ref_ovr;
  logic [15:0] addr_pool [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    step();
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = 8'($urandom);
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      step();
      check_val("busy_gap", 32'(u_if.busy), 32'(1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_bus_req"},   32'(u_if.bus_req),   32'(0));
    check_val({tag, "_bus_we"},    32'(u_if.bus_we),    32'(0));
    check_val({tag, "_bus_addr"},  32'(u_if.bus_addr),  32'(0));
    check_val({tag, "_bus_wdata"}, 32'(u_if.bus_wdata), 32'(0));
    check_val({tag, "_tx_valid"},  32'(u_if.tx_valid),  32'(0));
    check_val({tag, "_tx_data"},   32'(u_if.tx_data),   32'(0));
    check_val({tag, "_busy"},      32'(u_if.busy),      32'(0));
    check_val({tag, "_overrun"},   32'(u_if.overrun),   32'(0));
    check_val({tag, "_frame_err"}, 32'(u_if.frame_err), 32'(0));
    check_val({tag, "_cmd_err"},   32'(u_if.cmd_err),   32'(0));
  endtask

  // Bus phase and response phase after the last frame byte has been strobed.
  // ovr_mode: 0 no stray bytes, 1 random stray bytes, 2 stray byte every wait cycle
  task automatic finish_txn(input bit wr, input logic [15:0] a, input logic [7:0] d,
                            input int ack_dly, input int rdy_dly, input int ovr_mode);
    logic [7:0] exp_tx;
    check_val("bus_req_rise", 32'(u_if.bus_req), 32'(1));
    check_val("bus_we",       32'(u_if.bus_we),  32'(wr));
    check_val("bus_addr",     32'(u_if.bus_addr), 32'(a));
    if (wr) check_val("bus_wdata", 32'(u_if.bus_wdata), 32'(d));
    check_val("tx_valid_bus", 32'(u_if.tx_valid), 32'(0));
    for (int i = 0; i < ack_dly; i++) begin
      if (ovr_mode == 2 || (ovr_mode == 1 && $urandom_range(0, 3) == 0)) begin
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = 8'($urandom);
        ref_ovr       = 1'b1;
      end
      step();
      u_if.rx_valid = 1'b0;
      check_val("bus_req_hold",  32'(u_if.bus_req),  32'(1));
      check_val("bus_addr_hold", 32'(u_if.bus_addr), 32'(a));
    end
    if (u_if.bus_we) slave_mem[u_if.bus_addr] = u_if.bus_wdata;
    u_if.bus_rdata = slave_mem[u_if.bus_addr];
    u_if.bus_ack   = 1'b1;
    step();
    u_if.bus_ack   = 1'b0;
    u_if.bus_rdata = 8'($urandom);
    check_val("bus_req_fall", 32'(u_if.bus_req), 32'(0));
    if (wr) ref_mem[a] = d;
    exp_tx = wr ? ACK_B : ref_mem[a];
    if (!wr || WR_ACK) begin
      check_val("tx_valid_rise", 32'(u_if.tx_valid), 32'(1));
      check_val("tx_data",       32'(u_if.tx_data),  32'(exp_tx));
      for (int i = 0; i < rdy_dly; i++) begin
        step();
        check_val("tx_valid_hold", 32'(u_if.tx_valid), 32'(1));
        check_val("tx_data_hold",  32'(u_if.tx_data),  32'(exp_tx));
      end
      u_if.tx_ready = 1'b1;
      step();
      u_if.tx_ready = 1'b0;
      check_val("tx_valid_fall", 32'(u_if.tx_valid), 32'(0));
    end else begin
      check_val("tx_valid_wr_none", 32'(u_if.tx_valid), 32'(0));
    end
    check_val("busy_end",    32'(u_if.busy),    32'(0));
    check_val("overrun_end", 32'(u_if.overrun), 32'(ref_ovr));
  endtask

  task automatic do_frame(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input int ack_dly, input int rdy_dly, input int ovr_mode);
    send_byte(wr ? CMD_WR : CMD_RD);
    check_val("busy_cmd", 32'(u_if.busy), 32'(1));
    idle_gap();
    send_byte(a[15:8]);
    idle_gap();
    send_byte(a[7:0]);
    if (wr) begin
      check_val("bus_req_data_wait", 32'(u_if.bus_req), 32'(0));
      idle_gap();
      send_byte(d);
    end
    finish_txn(wr, a, d, ack_dly, rdy_dly, ovr_mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    u_if.rx_valid  = 1'b0;
    u_if.rx_data   = 8'h00;
    u_if.bus_ack   = 1'b0;
    u_if.bus_rdata = 8'h00;
    u_if.tx_ready  = 1'b0;
    ref_ovr        = 1'b0;
    addr_pool[0] = 16'h1234;
    addr_pool[1] = 16'h0010;
    addr_pool[2] = 16'hFF01;
    addr_pool[3] = 16'h00FF;
    for (int i = 0; i < 65536; i++) begin
      slave_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[16'h0010] = 8'h5C;
    ref_mem[16'h0010]   = 8'h5C;

    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
    check_val("idle_busy", 32'(u_if.busy), 32'(0));

    // write 57 12 34 AB, then read 52 00 10 with ack 3 cycles late
    do_frame(1'b1, 16'h1234, 8'hAB, 0, 0, 0);
    do_frame(1'b0, 16'h0010, 8'h00, 3, 2, 0);
    do_frame(1'b0, 16'h1234, 8'h00, 0, 0, 0);

    // unknown command then a normal read
    send_byte(8'h41);
    check_val("cmd_err_pulse", 32'(u_if.cmd_err), 32'(1));
    check_val("cmd_err_busy",  32'(u_if.busy),    32'(0));
    step();
    check_val("cmd_err_clear", 32'(u_if.cmd_err), 32'(0));
    check_val("cmd_err_noreq", 32'(u_if.bus_req), 32'(0));
    do_frame(1'b0, 16'h0001, 8'h00, 1, 1, 0);

    // inter-byte timeout: silence for TO cycles after the address high byte
    send_byte(CMD_WR);
    send_byte(8'h12);
    for (int i = 1; i < int'(TO); i++) begin
      step();
      check_val("to_no_err_early", 32'(u_if.frame_err), 32'(0));
    end
    step();
    check_val("to_frame_err", 32'(u_if.frame_err), 32'(1));
    check_val("to_busy",      32'(u_if.busy),      32'(0));
    check_val("to_bus_req",   32'(u_if.bus_req),   32'(0));
    step();
    check_val("to_err_clear", 32'(u_if.frame_err), 32'(0));
    do_frame(1'b1, 16'h00FF, 8'h3C, 1, 0, 0);

    // byte landing exactly in the expiry cycle wins
    send_byte(CMD_WR);
    send_byte(8'h12);
    for (int i = 1; i < int'(TO); i++) step();
    send_byte(8'h34);
    check_val("exp_byte_no_err", 32'(u_if.frame_err), 32'(0));
    check_val("exp_byte_busy",   32'(u_if.busy),      32'(1));
    send_byte(8'h77);
    finish_txn(1'b1, 16'h1234, 8'h77, 0, 0, 0);

    // overrun while bus_req is held
    do_frame(1'b0, 16'h1234, 8'h00, 2, 1, 2);
    check_val("overrun_set", 32'(u_if.overrun), 32'(1));

    for (int n = 0; n < 50; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do b = 8'($urandom); while (b == CMD_WR || b == CMD_RD);
        send_byte(b);
        check_val("rnd_cmd_err",   32'(u_if.cmd_err), 32'(1));
        check_val("rnd_cmd_busy",  32'(u_if.busy),    32'(0));
        step();
        check_val("rnd_cmd_clear", 32'(u_if.cmd_err), 32'(0));
      end else begin
        do_frame(r < 5, addr_pool[$urandom_range(0, 3)], 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    check_val("overrun_sticky", 32'(u_if.overrun), 32'(1));

    // reset while bus_req is high; a late ack must be ignored
    send_byte(CMD_RD);
    send_byte(8'h00);
    send_byte(8'h10);
    check_val("mid_bus_req", 32'(u_if.bus_req), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_ovr = 1'b0;
    check_reset_outputs("rst_bus");
    u_if.bus_ack   = 1'b1;
    u_if.bus_rdata = 8'hEE;
    step();
    u_if.bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_no_tx",   32'(u_if.tx_valid), 32'(0));
      check_val("rst_no_busy", 32'(u_if.busy),     32'(0));
      step();
    end
    do_frame(1'b0, 16'h00FF, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer placed after the UART receiver on the system bus. It parses the received byte stream into read and write command frames and drives single-beat bus transactions from them. Read data, and write acknowledges when enabled, go back to the UART transmitter. Inter-byte timeout and overrun tracking keep a corrupted stream from hanging the bus.

## Interface
- `TIMEOUT_CYCLES`, 100000: max clocks between bytes of one frame before the partial frame is discarded
- `CMD_WR`, 8'h57: write command byte
- `CMD_RD`, 8'h52: read command byte
- `ACK_BYTE`, 8'h06: byte sent for a completed write (`UART_CMD_WR_ACK_EN` only)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: synchronous active-high reset
- `rx_valid` in 1: one-cycle strobe, `rx_data` is a new byte
- `rx_data` in 8: received byte
- `bus_req` out 1: transaction request, held until `bus_ack`
- `bus_we` out 1: 1 = write, 0 = read
- `bus_addr` out 16: transaction address
- `bus_wdata` out 8: write data
- `bus_ack` in 1: one-cycle completion from the bus
- `bus_rdata` in 8: read data, valid with `bus_ack` on a read
- `tx_valid` out 1: response byte available
- `tx_data` out 8: response byte
- `tx_ready` in 1: transmitter accepts the byte when high with `tx_valid`
- `busy` out 1: state is not IDLE
- `overrun` out 1: sticky; a byte arrived during BUS or RESP
- `frame_err` out 1: one-cycle pulse on inter-byte timeout
- `cmd_err` out 1: one-cycle pulse on an unknown command byte

## Operation
- Frame formats:
  - Write: `CMD_WR`, ADDR_HI, ADDR_LO, DATA.
  - Read: `CMD_RD`, ADDR_HI, ADDR_LO.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, RESP.
- IDLE:
  - `rx_valid` with `CMD_WR` or `CMD_RD` latches `bus_we` and goes to ADDR_HI.
  - `rx_valid` with any other byte pulses `cmd_err` and stays in IDLE.
- ADDR_HI latches `bus_addr[15:8]`, then goes to ADDR_LO.
- ADDR_LO latches `bus_addr[7:0]`. A write goes to DATA; a read goes to BUS.
- DATA latches `bus_wdata`, then goes to BUS.
- BUS:
  - `bus_req`=1, with `bus_we`, `bus_addr` and `bus_wdata` stable until `bus_ack`.
  - On `bus_ack`: a read captures `bus_rdata` into `tx_data` and goes to RESP.
  - On `bus_ack`: a write goes to RESP or IDLE, depending on the Configuration section.
- RESP: `tx_valid`=1 with `tx_data` stable. `tx_valid && tx_ready` returns to IDLE.
- Timeout:
  - The counter runs only in ADDR_HI, ADDR_LO and DATA. It clears on every `rx_valid` and on every state entry.
  - When it reaches `TIMEOUT_CYCLES`-1 with no `rx_valid`: go to IDLE and pulse `frame_err`.
  - If `rx_valid` arrives in the expiry cycle, the byte wins and no error is raised.
- Overrun:
  - `rx_valid` in BUS or RESP drops the byte and sets `overrun`. The state is unchanged.
  - `overrun` clears only on `rst`.
- Bus and TX waits are unbounded; there is no timeout in BUS or RESP.

## Timing
- Every output is registered.
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `overrun`=0, `frame_err`=0, `cmd_err`=0. State is IDLE.
- `rst` mid-frame, mid-BUS or mid-RESP: all outputs take reset values at the next edge, including `bus_req` and `tx_valid` dropping.
- `bus_req` rises the cycle after the final frame byte's `rx_valid`.
- `bus_ack` may arrive in the first cycle `bus_req` is high. `bus_req` falls the cycle after `bus_ack`.
- `bus_ack` is ignored whenever `bus_req`=0.
- `tx_valid` rises the cycle after `bus_ack`. It falls the cycle after the `tx_ready` handshake.
- Fastest read, from the ADDR_LO strobe: `bus_req` at +1. With ack and `tx_ready` immediate, `tx_valid` is seen at +2 and IDLE is reached at +3.
- Back-to-back frames: a new command byte is accepted the first cycle the FSM is back in IDLE.
- `cmd_err` and `frame_err` are high for exactly one cycle.

## Configuration
- `UART_CMD_WR_ACK_EN` defined:
  - A write's `bus_ack` goes to RESP with `tx_data`=`ACK_BYTE`.
  - `tx_valid` rises the cycle after `bus_ack`.
- Not defined:
  - A write's `bus_ack` returns directly to IDLE; `tx_valid` never rises for writes.
  - The `ACK_BYTE` parameter is unused.

## Test plan
- Write: bytes 57,12,34,AB -> one `bus_req` with `bus_we`=1, `bus_addr`=16'h1234, `bus_wdata`=AB. After ack, 06 appears on `tx_data` if `UART_CMD_WR_ACK_EN` is defined; otherwise `tx_valid` stays 0.
- Read: bytes 52,00,10 with `bus_rdata`=5C, ack delayed 3 cycles -> `bus_req` is held 4 cycles. `tx_valid` with `tx_data`=5C is held until `tx_ready`, then IDLE.
- Bad command byte 41 -> `cmd_err` pulses for 1 cycle, `bus_req` stays 0, and a following 52,00,01 frame completes normally.
- Timeout (`TIMEOUT_CYCLES`=20): bytes 57,12 then silence -> `frame_err` pulses, `busy`=0, and a later full frame completes normally. A third byte arriving exactly in the expiry cycle -> no error.
- Overrun: a byte strobed while `bus_req` is held -> `overrun`=1, the transaction is unaffected, and `overrun` stays 1 until `rst`.
- Reset mid-BUS: `rst` asserted while `bus_req`=1 -> all outputs take reset values next cycle, and no `tx_valid` follows.
